// File: rtl/ospi_flash_array.sv
// NOR-style flash array core behind the OSPI command decoder: write-enable latch,
// bit-clearing page program with busy time, sector/chip erase walking the array.
module ospi_flash_array #(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 8,
   parameter int SECTOR_WORDS = 16,
   parameter int PROG_CYCLES  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  busy,
   output logic                  wel,
   output logic                  done,
   output logic                  err
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int PCW   = $clog2(PROG_CYCLES + 1);
   localparam int CNT_W = (PCW > ADDR_WIDTH + 1) ? PCW : ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] SECTOR_MASK = ADDR_WIDTH'(SECTOR_WORDS - 1);

   localparam logic [2:0] OP_READ         = 3'd0;
   localparam logic [2:0] OP_WREN         = 3'd1;
   localparam logic [2:0] OP_WRDI         = 3'd2;
   localparam logic [2:0] OP_PROGRAM      = 3'd3;
   localparam logic [2:0] OP_SECTOR_ERASE = 3'd4;
   localparam logic [2:0] OP_CHIP_ERASE   = 3'd5;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PROG = 2'd1, ST_ERASE = 2'd2} state_t;

   state_t                state_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [ADDR_WIDTH-1:0] ptr_r;
   logic [DATA_WIDTH-1:0] pdata_r;
   // Words are stored complemented so the power-up zero state reads back as erased.
   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic                  accept_s;
   logic                  we_s;
   logic [DATA_WIDTH-1:0] wdata_s;

   assign cmd_ready = (state_r == ST_IDLE);
   assign accept_s  = cmd_valid && cmd_ready;

   // Array write strobe: final program word, or one erased word per ERASE cycle.
   always_comb begin
      we_s    = 1'b0;
      wdata_s = {DATA_WIDTH{1'b0}};
      if (reset) begin
         we_s = 1'b0;
      end else begin
         case (state_r)
            ST_PROG: begin
               we_s    = (cnt_r == CNT_W'(0));
               wdata_s = pdata_r;
            end
            ST_ERASE: begin
               we_s    = 1'b1;
               wdata_s = {DATA_WIDTH{1'b0}};
            end
            default: begin
               we_s = 1'b0;
            end
         endcase
      end
   end

   // Storage array, deliberately outside reset so contents survive it.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_r[ptr_r] <= wdata_s;
      end
   end

   // Command FSM, busy counters and registered strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         cnt_r    <= CNT_W'(0);
         ptr_r    <= ADDR_WIDTH'(0);
         pdata_r  <= {DATA_WIDTH{1'b0}};
         busy     <= 1'b0;
         wel      <= 1'b0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         data_out <= {DATA_WIDTH{1'b0}};
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  case (cmd_op)
                     OP_READ: begin
                        data_out <= ~mem_r[address];
                        rd_valid <= 1'b1;
                     end
                     OP_WREN: wel <= 1'b1;
                     OP_WRDI: wel <= 1'b0;
                     OP_PROGRAM: begin
                        if (wel) begin
                           state_r <= ST_PROG;
                           busy    <= 1'b1;
                           cnt_r   <= CNT_W'(PROG_CYCLES - 1);
                           ptr_r   <= address;
                           // Complemented AND: programming can only clear bits.
                           pdata_r <= mem_r[address] | ~data_in;
                        end else begin
                           err <= 1'b1;
                        end
                     end
                     OP_SECTOR_ERASE: begin
                        if (wel) begin
                           state_r <= ST_ERASE;
                           busy    <= 1'b1;
                           cnt_r   <= CNT_W'(SECTOR_WORDS);
                           ptr_r   <= address & ~SECTOR_MASK;
                        end else begin
                           err <= 1'b1;
                        end
                     end
                     OP_CHIP_ERASE: begin
                        if (wel) begin
                           state_r <= ST_ERASE;
                           busy    <= 1'b1;
                           cnt_r   <= CNT_W'(DEPTH);
                           ptr_r   <= ADDR_WIDTH'(0);
                        end else begin
                           err <= 1'b1;
                        end
                     end
                     default: err <= 1'b1;
                  endcase
               end
            end
            ST_PROG: begin
               if (cnt_r == CNT_W'(0)) begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
                  wel     <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            ST_ERASE: begin
               ptr_r <= ptr_r + ADDR_WIDTH'(1);
               cnt_r <= cnt_r - CNT_W'(1);
               if (cnt_r == CNT_W'(1)) begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
                  wel     <= 1'b0;
                  done    <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ospi_flash_array.sv
// Randomised scoreboard bench for ospi_flash_array: default instance plus a small
// (ADDR_WIDTH=4, DATA_WIDTH=16, PROG_CYCLES=1) instance.
module tb_ospi_flash_array;
   localparam logic [2:0] OP_READ = 3'd0, OP_WREN = 3'd1, OP_WRDI = 3'd2;
   localparam logic [2:0] OP_PROG = 3'd3, OP_SE = 3'd4, OP_CE = 3'd5;
   localparam int EV_READ = 0, EV_ERR = 1, EV_DONE = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
   logic       cmd_ready, rd_valid, busy, wel, done, err;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] address = 8'h00, data_in = 8'h00, data_out;

   logic        b_reset = 1'b1, b_cmd_valid = 1'b0;
   logic        b_cmd_ready, b_rd_valid, b_busy, b_wel, b_done, b_err;
   logic [2:0]  b_cmd_op = 3'd0;
   logic [3:0]  b_address = 4'h0;
   logic [15:0] b_data_in = 16'h0000, b_data_out;

   int          checks = 0, errors = 0, ready_bad = 0;
   logic [7:0]  mem_m [256];
   logic        wel_m = 1'b0;
   ev_t         exp_q[$];
   logic [15:0] b_mem_m [16];
   logic [15:0] b_q[$];
   int          b_done_seen = 0, b_done_exp = 0, b_err_seen = 0;

   always #5 clk = ~clk;

   ospi_flash_array dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .address(address), .data_in(data_in), .rd_valid(rd_valid),
      .data_out(data_out), .busy(busy), .wel(wel), .done(done), .err(err)
   );

   ospi_flash_array #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .SECTOR_WORDS(16), .PROG_CYCLES(1)) dut_b (
      .clk(clk), .reset(b_reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_op(b_cmd_op), .address(b_address), .data_in(b_data_in), .rd_valid(b_rd_valid),
      .data_out(b_data_out), .busy(b_busy), .wel(b_wel), .done(b_done), .err(b_err)
   );

   function automatic void chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void push_ev(input int k, input logic [7:0] d);
      ev_t e;
      e.kind = k;
      e.data = d;
      exp_q.push_back(e);
   endfunction

   // Monitor for the default instance: every strobe must match the next expected event.
   always @(negedge clk) begin
      ev_t e;
      int  kind;
      if (!reset) begin
         if ((err && done) || (rd_valid && busy)) begin
            checks++;
            errors++;
            $display("FAIL strobe_overlap got err=%0b done=%0b rd_valid=%0b busy=%0b expected exclusive",
                     err, done, rd_valid, busy);
         end
         if (rd_valid || err || done) begin
            kind = rd_valid ? EV_READ : (err ? EV_ERR : EV_DONE);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event got kind %0d expected none", kind);
            end else begin
               e = exp_q.pop_front();
               chk("event_kind", kind, e.kind);
               if (kind == EV_READ && e.kind == EV_READ) chk("read_data", data_out, e.data);
            end
         end
      end
   end

   // Monitor for the small instance.
   always @(negedge clk) begin
      if (!b_reset) begin
         if (b_done) b_done_seen++;
         if (b_err) b_err_seen++;
         if (b_rd_valid) begin
            if (b_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_unexpected_read got %0h expected none", b_data_out);
            end else begin
               chk("b_read_data", b_data_out, b_q.pop_front());
            end
         end
      end
   end

   // Issue one command; the model applies the NOR rules and, for program/erase,
   // the busy window is measured. abort_at >= 0 resets after that many erased words.
   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d, input int abort_at);
      int guard, n, words, base;
      guard = 0;
      @(negedge clk);
      while (!cmd_ready && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout got busy expected idle");
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      address   = a;
      data_in   = d;
      @(posedge clk);
      if (op > OP_CE || ((op == OP_PROG || op == OP_SE || op == OP_CE) && !wel_m)) begin
         push_ev(EV_ERR, 8'h00);
      end else if (op == OP_READ) begin
         push_ev(EV_READ, mem_m[a]);
      end else if (op == OP_WREN) begin
         wel_m = 1'b1;
      end else if (op == OP_WRDI) begin
         wel_m = 1'b0;
      end else begin
         words = (op == OP_PROG) ? 4 : ((op == OP_SE) ? 16 : 256);
         base  = (op == OP_SE) ? int'(a & 8'hF0) : 0;
         if (abort_at < 0) begin
            if (op == OP_PROG) mem_m[a] = mem_m[a] & d;
            else for (int i = 0; i < words; i++) mem_m[(base + i) % 256] = 8'hFF;
            push_ev(EV_DONE, 8'h00);
            @(negedge clk);
            cmd_valid = 1'b0;
            n = 0;
            while (busy && n < 2000) begin
               if (cmd_ready) ready_bad++;
               n++;
               @(negedge clk);
            end
            chk("busy_cycles", n, words);
         end else begin
            if (op != OP_PROG) for (int i = 0; i < abort_at; i++) mem_m[(base + i) % 256] = 8'hFF;
            repeat (abort_at) @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
         wel_m = 1'b0;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("wel", wel, wel_m);
      chk("busy_idle", busy, 0);
   endtask

   task automatic b_cmd(input logic [2:0] op, input logic [3:0] a, input logic [15:0] d, input int exp_busy);
      int guard, n;
      guard = 0;
      @(negedge clk);
      while (!b_cmd_ready && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      b_cmd_valid = 1'b1;
      b_cmd_op    = op;
      b_address   = a;
      b_data_in   = d;
      @(posedge clk);
      case (op)
         OP_READ: b_q.push_back(b_mem_m[a]);
         OP_PROG: begin
            b_mem_m[a] = b_mem_m[a] & d;
            b_done_exp++;
         end
         OP_CE: begin
            for (int i = 0; i < 16; i++) b_mem_m[i] = 16'hFFFF;
            b_done_exp++;
         end
         default: ;
      endcase
      @(negedge clk);
      b_cmd_valid = 1'b0;
      n = 0;
      while (b_busy && n < 2000) begin
         n++;
         @(negedge clk);
      end
      chk("b_busy_cycles", n, exp_busy);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, bad, r, k;
      logic [7:0] a, d;
      for (int i = 0; i < 256; i++) mem_m[i] = 8'hFF;
      for (int i = 0; i < 16; i++) b_mem_m[i] = 16'hFFFF;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      b_reset = 1'b0;
      @(negedge clk);
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_data_out", data_out, 0);
      chk("reset_busy", busy, 0);
      chk("reset_wel", wel, 0);
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_done_err", {done, err}, 0);

      send(OP_READ, 8'h10, 8'h00, -1); idle();
      send(OP_PROG, 8'h10, 8'hA5, -1); idle();
      send(OP_WREN, 8'h00, 8'h00, -1); send(OP_PROG, 8'h10, 8'hA5, -1);
      send(OP_READ, 8'h10, 8'h00, -1); idle();
      send(OP_WREN, 8'h00, 8'h00, -1); send(OP_PROG, 8'h10, 8'h5A, -1);
      send(OP_READ, 8'h10, 8'h00, -1); idle();

      send(OP_WREN, 8'h00, 8'h00, -1); send(OP_PROG, 8'h23, 8'h12, -1);
      send(OP_WREN, 8'h00, 8'h00, -1); send(OP_PROG, 8'h2F, 8'h34, -1);
      send(OP_WREN, 8'h00, 8'h00, -1); send(OP_PROG, 8'h30, 8'h77, -1);
      send(OP_WREN, 8'h00, 8'h00, -1); send(OP_SE, 8'h27, 8'h00, -1);
      for (int j = 0; j < 17; j++) send(OP_READ, 8'h20 + 8'(j), 8'h00, -1);
      idle();

      // Chip erase with a READ held on cmd_valid throughout the busy window.
      send(OP_WREN, 8'h00, 8'h00, -1);
      @(negedge clk);
      cmd_op  = OP_CE;
      address = 8'h00;
      @(posedge clk);
      for (int i = 0; i < 256; i++) mem_m[i] = 8'hFF;
      push_ev(EV_DONE, 8'h00);
      push_ev(EV_READ, 8'hFF);
      @(negedge clk);
      cmd_op  = OP_READ;
      address = 8'h30;
      n = 0;
      bad = 0;
      while (busy && n < 2000) begin
         if (cmd_ready) bad++;
         n++;
         @(negedge clk);
      end
      chk("chip_erase_busy", n, 256);
      chk("chip_erase_ready_low", bad, 0);
      wel_m = 1'b0;
      idle();

      for (int j = 0; j < 16; j++) begin
         send(OP_WREN, 8'h00, 8'h00, -1);
         send(OP_PROG, 8'h40 + 8'(j), 8'($urandom), -1);
      end
      send(OP_WREN, 8'h00, 8'h00, -1);
      send(OP_SE, 8'h40, 8'h00, 5);
      for (int j = 0; j < 16; j++) send(OP_READ, 8'h40 + 8'(j), 8'h00, -1);
      idle();
      send(OP_PROG, 8'h00, 8'h00, 7); idle();
      send(OP_WREN, 8'h00, 8'h00, -1); send(3'd7, 8'h00, 8'h00, -1); idle();
      send(3'd6, 8'h00, 8'h00, -1); idle();
      send(OP_WRDI, 8'h00, 8'h00, -1); idle();

      for (int it = 0; it < 80; it++) begin
         r = $urandom_range(0, 99);
         a = 8'($urandom);
         d = 8'($urandom);
         if (r < 30) begin
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) send(OP_READ, a + 8'(j), 8'h00, -1);
         end else if (r < 40) begin
            send(OP_WREN, 8'h00, 8'h00, -1);
         end else if (r < 45) begin
            send(OP_WRDI, 8'h00, 8'h00, -1);
         end else if (r < 75) begin
            if ($urandom_range(0, 3) != 0) send(OP_WREN, 8'h00, 8'h00, -1);
            send(OP_PROG, a, d, -1);
         end else if (r < 88) begin
            if ($urandom_range(0, 3) != 0) send(OP_WREN, 8'h00, 8'h00, -1);
            send(OP_SE, a, 8'h00, -1);
         end else if (r < 91) begin
            send(OP_WREN, 8'h00, 8'h00, -1);
            send(OP_CE, a, 8'h00, -1);
         end else begin
            send(3'(6 + $urandom_range(0, 1)), a, d, -1);
         end
         idle();
      end

      b_cmd(OP_WREN, 4'h0, 16'h0000, 0);
      b_cmd(OP_PROG, 4'h3, 16'h1234, 1);
      b_cmd(OP_READ, 4'h3, 16'h0000, 0);
      b_cmd(OP_WREN, 4'h0, 16'h0000, 0);
      b_cmd(OP_PROG, 4'hF, 16'h00F0, 1);
      b_cmd(OP_WREN, 4'h0, 16'h0000, 0);
      b_cmd(OP_PROG, 4'hF, 16'h0F0F, 1);
      b_cmd(OP_READ, 4'hF, 16'h0000, 0);
      b_cmd(OP_WREN, 4'h0, 16'h0000, 0);
      b_cmd(OP_CE, 4'h7, 16'h0000, 16);
      for (int j = 0; j < 16; j++) b_cmd(OP_READ, 4'(j), 16'h0000, 0);
      chk("b_wel_after_erase", b_wel, 0);

      repeat (4) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("b_queue_drained", b_q.size(), 0);
      chk("b_done_count", b_done_seen, b_done_exp);
      chk("b_err_count", b_err_seen, 0);
      chk("ready_during_busy", ready_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ospi_flash_array.md
# ospi_flash_array

Parametrised, synthesizable flash-array core that replaces the fixed 8-bit, 256-word flash behavioural model behind the OSPI front end. It adds NOR-flash semantics the earlier model lacks:
- a write-enable latch;
- bit-clearing page program with busy time;
- sector and chip erase that walk the array;
- an error strobe.

It sits between the OSPI command decoder and the storage array. It accepts one decoded command per handshake and returns read data and status.

## Interface

Parameters:
- ADDR_WIDTH, 8, word-address width; DEPTH = 2**ADDR_WIDTH
- DATA_WIDTH, 8, word width
- SECTOR_WORDS, 16, words per erase sector; power of two, ≤ DEPTH
- PROG_CYCLES, 4, program busy time in clk cycles; ≥ 1

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  core can accept a command; combinational, = (state==IDLE)
- cmd_op  in  3  0 READ, 1 WREN, 2 WRDI, 3 PROGRAM, 4 SECTOR_ERASE, 5 CHIP_ERASE, 6–7 illegal
- address  in  ADDR_WIDTH  word address
- data_in  in  DATA_WIDTH  program data
- rd_valid  out  1  one-cycle strobe; data_out valid
- data_out  out  DATA_WIDTH  read data; holds last value
- busy  out  1  program/erase in progress
- wel  out  1  write-enable latch
- done  out  1  one-cycle strobe at program/erase completion
- err  out  1  one-cycle strobe for a rejected command

## Operation

- A command is accepted on a rising edge with cmd_valid && cmd_ready. The address, data and opcode are captured at that edge.
- States: IDLE, PROG, ERASE.
- READ (IDLE→IDLE):
  - data_out <= mem[address] and rd_valid=1 in the next cycle.
  - Back-to-back reads are allowed every cycle.
- WREN / WRDI (IDLE→IDLE): set / clear wel at the next edge.
- PROGRAM:
  - If wel=0: err=1 next cycle, no state change.
  - Else: go to PROG and load counter = PROG_CYCLES-1.
  - On the counter==0 edge: mem[addr] <= mem[addr] & data_in (bits only clear, never set), then wel<=0, done<=1, go to IDLE.
- SECTOR_ERASE:
  - If wel=0: err.
  - Else: ptr <= address with the low log2(SECTOR_WORDS) bits cleared, and remaining = SECTOR_WORDS; go to ERASE.
- CHIP_ERASE: same as SECTOR_ERASE with ptr=0 and remaining = DEPTH.
- ERASE state:
  - Each edge writes all-ones to mem[ptr], increments ptr and decrements remaining.
  - On the last word: wel<=0, done<=1, go to IDLE.
  - ptr wraps modulo DEPTH; never crosses its region because sectors are aligned.
- Illegal opcode (6, 7): err=1 next cycle; wel unchanged.
- No command is accepted in PROG or ERASE; cmd_ready=0 there. cmd_valid held high is accepted at the first IDLE cycle.
- Memory array:
  - Not cleared by reset.
  - Simulation initial contents are all-ones (erased).
  - Single write port, one read port.

## Timing

- Reset values: state IDLE, busy 0, wel 0, rd_valid 0, done 0, err 0, data_out 0, counters 0. cmd_ready=1 from the first cycle after reset deasserts.
- READ latency is 1 cycle: accepted at edge E0, data valid after E0, rd_valid high for one cycle.
- PROGRAM accepted at E0:
  - busy=1 after E0 through E_PROG_CYCLES; mem is written at E_PROG_CYCLES.
  - In the cycle after E_PROG_CYCLES: busy=0, done=1, wel=0, cmd_ready=1.
- Erase of N words accepted at E0: words are written at E1..EN, busy is high for exactly N cycles, and done follows EN.
- A READ issued the cycle after done returns the updated data.
- err and done are never high together; rd_valid never coincides with busy.
- Reset mid-PROG aborts the program; the word is unchanged.
- Reset mid-ERASE leaves the words already written erased and the rest untouched.
- In both reset cases: wel=0, busy=0, no done.
- reset has priority over cmd_valid in the same cycle; the command is dropped.

## Test plan

Default parameters unless noted.
- Reset, then READ addr 0x10 → rd_valid one cycle later, data_out=0xFF; wel=0, busy=0.
- PROGRAM 0x10 with wel=0 → err pulse, mem unchanged. Then WREN, PROGRAM 0x10 data 0xA5 → busy 4 cycles, done pulse, wel=0; READ → 0xA5. Then WREN, PROGRAM 0x10 data 0x5A → READ returns 0x00 (AND semantics).
- After programming 0x23 and 0x2F, WREN, SECTOR_ERASE addr 0x27 → busy 16 cycles; READ 0x20..0x2F → 0xFF; a word programmed at 0x30 still reads its value.
- WREN, CHIP_ERASE → busy exactly 256 cycles, cmd_ready=0 throughout; a cmd_valid READ held high is accepted on the first IDLE cycle and returns 0xFF.
- WREN, SECTOR_ERASE at 0x40, assert reset after 5 busy cycles → 0x40..0x44 read 0xFF, 0x45..0x4F keep their prior values, wel=0, no done. Illegal opcode 7 → err pulse only.
- PROG_CYCLES=1, DATA_WIDTH=16, ADDR_WIDTH=4 → program busy 1 cycle; CHIP_ERASE busy 16 cycles; ptr wraps without touching out-of-range addresses.
